// File: rtl/vedic_pkg.sv
// Shared types and elaboration helpers for the sequential Vedic multiplier.
package vedic_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int digits(int width, int bw);
    return width / bw;
  endfunction

  function automatic bit width_ok(int width, int bw);
    return (bw > 0) && (width % bw == 0);
  endfunction

  function automatic int pow2_ceil(int x);
    int r;
    r = 1;
    while (r < x) r = r * 2;
    return r;
  endfunction

endpackage

// File: rtl/vedic_pp_unit.sv
// Combinational BW x BW Vedic (Urdhva) multiplier, built recursively down to 2x2 cells.
module vedic_pp_unit
  import vedic_pkg::*;
#(
  parameter int BW = 12
) (
  input  logic [BW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic [2*BW-1:0] p
);

  localparam int P = pow2_ceil(BW);

  if (BW == 1) begin : g_bit
    assign p = {1'b0, a[0] & b[0]};
  end else if (BW == 2) begin : g_cell
    logic c1;
    assign c1   = a[1] & b[0] & a[0] & b[1];
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = a[1] & b[1] & c1;
  end else if (P != BW) begin : g_pad
    // Non power-of-two digits ride on the next power-of-two core; upper bits are always zero.
    logic [2*P-1:0]    pw;
    logic [2*P-1:2*BW] unused_hi;
    vedic_pp_unit #(.BW(P)) u_core (
      .a({{(P-BW){1'b0}}, a}),
      .b({{(P-BW){1'b0}}, b}),
      .p(pw)
    );
    assign p         = pw[2*BW-1:0];
    assign unused_hi = pw[2*P-1:2*BW];
  end else begin : g_split
    localparam int H = BW / 2;
    logic [BW-1:0] ll, lh, hl, hh;
    logic [BW:0]   mid;
    vedic_pp_unit #(.BW(H)) u_ll (.a(a[H-1:0]),  .b(b[H-1:0]),  .p(ll));
    vedic_pp_unit #(.BW(H)) u_lh (.a(a[H-1:0]),  .b(b[BW-1:H]), .p(lh));
    vedic_pp_unit #(.BW(H)) u_hl (.a(a[BW-1:H]), .b(b[H-1:0]),  .p(hl));
    vedic_pp_unit #(.BW(H)) u_hh (.a(a[BW-1:H]), .b(b[BW-1:H]), .p(hh));
    assign mid = {1'b0, lh} + {1'b0, hl};
    assign p   = {hh, ll} + {{(BW-H-1){1'b0}}, mid, {H{1'b0}}};
  end

endmodule

// File: rtl/vedic_mul_seq.sv
// Sequential WIDTH x WIDTH unsigned multiplier / MAC iterating one BW x BW Vedic core over all digit pairs.
module vedic_mul_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int BW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_acc,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [2*WIDTH-1:0] out_rslt,
  output logic               busy
);

  localparam int N  = digits(WIDTH, BW);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = 2 * WIDTH;
  localparam logic [CW-1:0] DMAX = CW'(N - 1);

  if (!width_ok(WIDTH, BW)) begin : g_chk
    $error("vedic_mul_seq: WIDTH must be a multiple of BW");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    i_q, j_q;
  logic [CW:0]      sh_q;
  logic [RW-1:0]    acc_q, last_q, sum;
  logic [2*BW-1:0]  p, pp_q;
  logic [BW-1:0]    da, db;
  // [0]: a digit pair is being issued, [1]: pp_q holds a valid partial product
  logic [1:0]       vld_pipe;
  logic             fin_q, end_ij, accept;

  assign in_rdy  = (state_q == IDLE) && !rst;
  assign out_vld = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign accept  = in_vld && in_rdy;
  assign end_ij  = (i_q == DMAX) && (j_q == DMAX);

  assign da = a_q[int'(i_q)*BW +: BW];
  assign db = b_q[int'(j_q)*BW +: BW];

  vedic_pp_unit #(.BW(BW)) u_pp (.a(da), .b(db), .p(p));

  assign sum = acc_q + (RW'(pp_q) << (BW * int'(sh_q)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = CALC;
      CALC:    if (fin_q)   state_d = DONE;
      DONE:    if (out_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Partial products are registered, so accumulation trails digit issue by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      sh_q     <= '0;
      pp_q     <= '0;
      vld_pipe <= '0;
      fin_q    <= 1'b0;
      acc_q    <= '0;
      last_q   <= '0;
      out_rslt <= '0;
    end else begin
      pp_q        <= p;
      sh_q        <= {1'b0, i_q} + {1'b0, j_q};
      vld_pipe[1] <= vld_pipe[0];
      fin_q       <= vld_pipe[0] && end_ij;
      if (accept) begin
        a_q         <= in_a;
        b_q         <= in_b;
        i_q         <= '0;
        j_q         <= '0;
        vld_pipe[0] <= 1'b1;
        acc_q       <= in_acc ? last_q : '0;
      end else begin
        if (vld_pipe[0]) begin
          if (end_ij) begin
            vld_pipe[0] <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
          end else if (j_q == DMAX) begin
            j_q <= '0;
            i_q <= i_q + CW'(1);
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
        if (vld_pipe[1]) acc_q <= sum;
      end
      if (fin_q) begin
        out_rslt <= sum;
        last_q   <= sum;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Self-checking bench for vedic_mul_seq: table vectors, random MAC vectors, backpressure and abort.
module tb_vedic_mul_seq;

  localparam int W  = 48;
  localparam int RW = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_acc = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [RW-1:0] out_rslt;
  logic          busy;

  vedic_mul_seq #(.WIDTH(W), .BW(12)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_rslt(out_rslt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          acc;
    logic [RW-1:0] exp;
  } tv_t;

  int            n_run  = 0;
  int            n_fail = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] model_last = '0;

  task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted result handshake pops one expected value.
  always @(negedge clk) begin
    #1;
    if (!rst && out_vld && out_rdy) begin
      if (exp_q.size() == 0) check("unexpected_out", RW'(1), RW'(0));
      else                   check("rslt", out_rslt, exp_q.pop_front());
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                       input logic [RW-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      check("rdy_timeout", RW'(in_rdy), RW'(1));
      return;
    end
    in_vld = 1'b1; in_a = a; in_b = b; in_acc = acc;
    exp_q.push_back(exp);
    model_last = exp;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", RW'(n), RW'(17));
    if (out_rdy) begin
      @(posedge clk);
      #1;
      check("rdy_after", RW'({out_vld, in_rdy}), RW'(2'b01));
    end
  endtask

  tv_t           tv[7];
  logic [RW-1:0] r, prod;
  logic [W-1:0]  ra, rb;
  logic          racc, seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 96'hFFFFFFFFFFFE000000000001};
    tv[1] = '{48'h123456789ABC, 48'h1,            1'b0, 96'h123456789ABC};
    tv[2] = '{48'd3,            48'd5,            1'b0, 96'd15};
    tv[3] = '{48'd2,            48'd7,            1'b1, 96'd29};
    tv[4] = '{48'd1,            48'd1,            1'b0, 96'd1};
    tv[5] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 96'hFFFFFFFFFFFE000000000001};
    tv[6] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 96'hFFFFFFFFFFFC000000000002};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", RW'(out_vld), RW'(0));
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_out_rslt", out_rslt, RW'(0));
    check("rst_in_rdy", RW'(in_rdy), RW'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_rdy_after_rst", RW'(in_rdy), RW'(1));

    for (int k = 0; k < 7; k++) do_op(tv[k].a, tv[k].b, tv[k].acc, tv[k].exp);

    // random MAC vectors against the bench model
    for (int k = 0; k < 6; k++) begin
      ra   = W'({$urandom, $urandom});
      rb   = W'({$urandom, $urandom});
      racc = 1'($urandom_range(0, 1));
      prod = RW'(ra) * RW'(rb);
      do_op(ra, rb, racc, racc ? model_last + prod : prod);
    end

    // backpressure: result held in DONE for 10 cycles, in_vld ignored
    out_rdy = 1'b0;
    do_op(48'hABCDEF012345, 48'h00000000FFFF, 1'b0, RW'(48'hABCDEF012345) * RW'(48'h00000000FFFF));
    r = out_rslt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_vld = k[0];
      in_a   = W'($urandom);
      in_b   = W'($urandom);
      in_acc = 1'b0;
      #1;
      check("bp_hold", RW'({out_vld, in_rdy, busy}) ^ out_rslt ^ r, RW'(3'b101));
    end
    @(negedge clk);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", RW'({out_vld, in_rdy}), RW'(2'b01));
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      seen = seen | busy | out_vld;
    end
    check("bp_no_ghost_op", RW'(seen), RW'(0));

    // one-cycle reset at CALC cycle 8 aborts the op and clears the last result
    @(negedge clk);
    in_vld = 1'b1; in_a = 48'd5; in_b = 48'd5; in_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_in_calc", RW'(busy), RW'(1));
    rst = 1'b1;
    #1;
    check("abort_rdy_low", RW'(in_rdy), RW'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_state", RW'({in_rdy, busy, out_vld}), RW'(3'b100));
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen = seen | out_vld;
    end
    check("abort_no_vld", RW'(seen), RW'(0));
    model_last = '0;
    do_op(48'd1, 48'd1, 1'b1, RW'(1));

    repeat (5) @(negedge clk);
    check("queue_empty", RW'(exp_q.size()), RW'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
